// File: rtl/zacore_decode_sb_if.sv
// Decode-stage bus bundle: fetch handshake, execute output, writeback, control.
// slave  : the decode stage (drives fetch_ready, exec_*, occupancy)
// master : the surrounding pipeline / testbench
interface zacore_decode_sb_if #(
  parameter int INSTR_W    = 32,
  parameter int PC_W       = 32,
  parameter int DEPTH      = 4,
  parameter int REG_ADDR_W = 5
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  i_fetch_valid;
  logic                  o_fetch_ready;
  logic [INSTR_W-1:0]    i_fetch_instr;
  logic [PC_W-1:0]       i_fetch_pc;
  logic                  o_exec_valid;
  logic [INSTR_W-1:0]    o_exec_instr;
  logic [PC_W-1:0]       o_exec_pc;
  logic [REG_ADDR_W-1:0] o_exec_rs1;
  logic [REG_ADDR_W-1:0] o_exec_rs2;
  logic [REG_ADDR_W-1:0] o_exec_rd;
  logic                  o_exec_rd_we;
  logic                  i_wb_valid;
  logic [REG_ADDR_W-1:0] i_wb_rd;
  logic                  i_stall;
  logic                  i_invalidate;
  logic [CNT_W-1:0]      o_occupancy;

  modport slave (
    input  i_fetch_valid, i_fetch_instr, i_fetch_pc, i_wb_valid, i_wb_rd,
           i_stall, i_invalidate,
    output o_fetch_ready, o_exec_valid, o_exec_instr, o_exec_pc, o_exec_rs1,
           o_exec_rs2, o_exec_rd, o_exec_rd_we, o_occupancy
  );

  modport master (
    output i_fetch_valid, i_fetch_instr, i_fetch_pc, i_wb_valid, i_wb_rd,
           i_stall, i_invalidate,
    input  o_fetch_ready, o_exec_valid, o_exec_instr, o_exec_pc, o_exec_rs1,
           o_exec_rs2, o_exec_rd, o_exec_rd_we, o_occupancy
  );
endinterface

// File: rtl/zacore_decode_sb.sv
// zacore_decode_sb: decode stage between fetch and execute.
// - DEPTH-entry instruction FIFO fed by the fetch handshake.
// - Per-register scoreboard of pending writes; the FIFO head issues only when
//   none of rs1/rs2/rd is pending (RAW/WAW). Writeback clears bits.
// - Registered execute output honouring i_stall and i_invalidate.
// Ports: i_clk, i_rst (async, active-high), bus (zacore_decode_sb_if.slave).
// Option: define ZACORE_DECODE_BYPASS_EN to let a same-cycle writeback mask
//         its register out of the hazard check.
module zacore_decode_sb #(
  parameter int INSTR_W    = 32,
  parameter int PC_W       = 32,
  parameter int DEPTH      = 4,
  parameter int REG_ADDR_W = 5,
  parameter int RD_LSB     = 7,
  parameter int RS1_LSB    = 15,
  parameter int RS2_LSB    = 20
) (
  input  logic               i_clk,
  input  logic               i_rst,
  zacore_decode_sb_if.slave  bus
);
  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int NUM_REGS = 2 ** REG_ADDR_W;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } entry_t;

  entry_t                mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [NUM_REGS-1:0]   sb_q, sb_d, sb_eff;

  logic                  ex_valid_q, ex_rd_we_q;
  entry_t                ex_q;
  logic [REG_ADDR_W-1:0] ex_rs1_q, ex_rs2_q, ex_rd_q;

  entry_t                head;
  logic [REG_ADDR_W-1:0] hd_rs1, hd_rs2, hd_rd;
  logic                  fetch_ready, head_valid, hazard, can_issue, push;

  assign fetch_ready = (cnt_q != CNT_W'(DEPTH));
  assign head_valid  = (cnt_q != '0);
  assign head        = mem_q[rd_ptr_q];
  assign hd_rd       = head.instr[RD_LSB  +: REG_ADDR_W];
  assign hd_rs1      = head.instr[RS1_LSB +: REG_ADDR_W];
  assign hd_rs2      = head.instr[RS2_LSB +: REG_ADDR_W];

`ifdef ZACORE_DECODE_BYPASS_EN
  logic [NUM_REGS-1:0] wb_mask;
  always_comb begin
    wb_mask = '0;
    if (bus.i_wb_valid) wb_mask[bus.i_wb_rd] = 1'b1;
  end
  assign sb_eff = sb_q & ~wb_mask;
`else
  assign sb_eff = sb_q;
`endif

  // sb_q[0] is held at 0, so r0 operands never block.
  assign hazard    = sb_eff[hd_rs1] | sb_eff[hd_rs2] | sb_eff[hd_rd];
  assign can_issue = head_valid & ~hazard & (~ex_valid_q | ~bus.i_stall) &
                     ~bus.i_invalidate;
  // Ready uses the current count only: a pop this cycle does not free a slot.
  assign push      = bus.i_fetch_valid & fetch_ready & ~bus.i_invalidate;

  // Clears first, set last: an issue setting the same register wins.
  always_comb begin
    sb_d = sb_q;
    if (bus.i_wb_valid) sb_d[bus.i_wb_rd] = 1'b0;
    // A flushed instruction never writes back, so release its destination.
    if (bus.i_invalidate && ex_valid_q && ex_rd_we_q) sb_d[ex_rd_q] = 1'b0;
    if (can_issue && hd_rd != '0) sb_d[hd_rd] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      sb_q     <= '0;
    end else begin
      sb_q <= sb_d;
      if (bus.i_invalidate) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (push) begin
          mem_q[wr_ptr_q] <= '{instr: bus.i_fetch_instr, pc: bus.i_fetch_pc};
          wr_ptr_q        <= wr_ptr_q + 1'b1;  // DEPTH is a power of two
        end
        if (can_issue) rd_ptr_q <= rd_ptr_q + 1'b1;
        case ({push, can_issue})
          2'b10:   cnt_q <= cnt_q + 1'b1;
          2'b01:   cnt_q <= cnt_q - 1'b1;
          default: cnt_q <= cnt_q;
        endcase
      end
    end
  end

  // Execute output register: invalidate > issue > drain when not stalled.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
      ex_rs1_q   <= '0;
      ex_rs2_q   <= '0;
      ex_rd_q    <= '0;
      ex_rd_we_q <= 1'b0;
    end else if (bus.i_invalidate) begin
      ex_valid_q <= 1'b0;
    end else if (can_issue) begin
      ex_valid_q <= 1'b1;
      ex_q       <= head;
      ex_rs1_q   <= hd_rs1;
      ex_rs2_q   <= hd_rs2;
      ex_rd_q    <= hd_rd;
      ex_rd_we_q <= (hd_rd != '0);
    end else if (!bus.i_stall) begin
      ex_valid_q <= 1'b0;
    end
  end

  assign bus.o_fetch_ready = fetch_ready;
  assign bus.o_occupancy   = cnt_q;
  assign bus.o_exec_valid  = ex_valid_q;
  assign bus.o_exec_instr  = ex_q.instr;
  assign bus.o_exec_pc     = ex_q.pc;
  assign bus.o_exec_rs1    = ex_rs1_q;
  assign bus.o_exec_rs2    = ex_rs2_q;
  assign bus.o_exec_rd     = ex_rd_q;
  assign bus.o_exec_rd_we  = ex_rd_we_q;
endmodule

// File: tb/tb_zacore_decode_sb.sv
module tb_zacore_decode_sb;
  localparam int DEPTH = 4;
`ifdef ZACORE_DECODE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  zacore_decode_sb_if #(.INSTR_W(32), .PC_W(32), .DEPTH(DEPTH), .REG_ADDR_W(5)) bus ();
  zacore_decode_sb #(.INSTR_W(32), .PC_W(32), .DEPTH(DEPTH), .REG_ADDR_W(5),
                     .RD_LSB(7), .RS1_LSB(15), .RS2_LSB(20))
    dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  // ---------------- reference model: queue + register bit array ----------
  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
  ent_t        mq[$];
  bit   [31:0] m_sb;
  bit          m_ov;
  logic [31:0] m_instr, m_pc;

  function automatic int fld(logic [31:0] w, int lsb);
    return int'((w >> lsb) & 32'd31);
  endfunction

  function automatic logic [31:0] ins(int rd, int rs1, int rs2, logic [31:0] junk = 32'h33);
    logic [31:0] w;
    w = junk & ~((32'd31 << 7) | (32'd31 << 15) | (32'd31 << 20));
    return w | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(rd) << 7);
  endfunction

  function automatic bit pend(int r, bit wbv, int wbrd);
    return (r != 0) && m_sb[r] && !(BYP && wbv && wbrd == r);
  endfunction

  task automatic model_reset();
    mq.delete(); m_sb = '0; m_ov = 0; m_instr = '0; m_pc = '0;
  endtask

  task automatic model_step(bit fv, logic [31:0] instr, logic [31:0] pc,
                            bit wbv, int wbrd, bit stall, bit inv);
    bit ready, issue;
    ent_t e;
    ready = (mq.size() != DEPTH);
    issue = 0;
    if (mq.size() > 0 && !inv && (!m_ov || !stall))
      issue = !(pend(fld(mq[0].instr, 15), wbv, wbrd) ||
                pend(fld(mq[0].instr, 20), wbv, wbrd) ||
                pend(fld(mq[0].instr, 7),  wbv, wbrd));
    if (wbv) m_sb[wbrd] = 0;
    if (inv) begin
      if (m_ov && fld(m_instr, 7) != 0) m_sb[fld(m_instr, 7)] = 0;
      mq.delete();
      m_ov = 0;
    end else begin
      if (issue) begin
        e = mq.pop_front();
        m_ov = 1; m_instr = e.instr; m_pc = e.pc;
        if (fld(e.instr, 7) != 0) m_sb[fld(e.instr, 7)] = 1;
      end else if (!(m_ov && stall)) m_ov = 0;
      if (fv && ready) mq.push_back('{instr: instr, pc: pc});
    end
    m_sb[0] = 0;
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [31:0] ri;
    ri = m_instr;
    checks++;
    if (bus.o_exec_valid !== m_ov || bus.o_exec_instr !== ri || bus.o_exec_pc !== m_pc ||
        bus.o_exec_rs1 !== 5'(fld(ri, 15)) || bus.o_exec_rs2 !== 5'(fld(ri, 20)) ||
        bus.o_exec_rd !== 5'(fld(ri, 7)) || bus.o_exec_rd_we !== (fld(ri, 7) != 0) ||
        bus.o_occupancy !== 3'(mq.size()) || bus.o_fetch_ready !== (mq.size() != DEPTH)) begin
      errors++;
      $display("FAIL model: got v=%0b pc=%0h ins=%0h rd=%0d we=%0b occ=%0d rdy=%0b expected v=%0b pc=%0h ins=%0h occ=%0d at %0t",
               bus.o_exec_valid, bus.o_exec_pc, bus.o_exec_instr, bus.o_exec_rd,
               bus.o_exec_rd_we, bus.o_occupancy, bus.o_fetch_ready,
               m_ov, m_pc, ri, mq.size(), $time);
    end
  endtask

  // One clock: drive inputs, advance model, sample 1ns after the edge.
  task automatic cyc(bit fv, logic [31:0] instr, logic [31:0] pc,
                     bit wbv = 0, int wbrd = 0, bit stall = 0, bit inv = 0);
    bus.i_fetch_valid = fv;  bus.i_fetch_instr = instr; bus.i_fetch_pc = pc;
    bus.i_wb_valid    = wbv; bus.i_wb_rd       = 5'(wbrd);
    bus.i_stall       = stall; bus.i_invalidate = inv;
    model_step(fv, instr, pc, wbv, wbrd, stall, inv);
    @(posedge i_clk); #1;
    check_model();
  endtask

  task automatic idle();
    cyc(0, '0, '0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit fv; int rd, rs1, rs2; logic [31:0] pc;
    bit wbv; int wbrd;
    bit ev; logic [31:0] epc; int eocc;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t row(bit fv, int rd, int rs1, int rs2, logic [31:0] pc,
                               bit wbv, int wbrd, bit ev, logic [31:0] epc, int eocc);
    vec_t v;
    v.fv = fv; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.pc = pc;
    v.wbv = wbv; v.wbrd = wbrd; v.ev = ev; v.epc = epc; v.eocc = eocc;
    return v;
  endfunction

  initial begin
    int ocnt;
    // Push rd3; then rd5 followed by a RAW reader of r5; wb r5 in row 6.
    tbl.push_back(row(1, 3, 1, 2, 32'h100, 0, 0, 0, 32'h000, 1));
    tbl.push_back(row(0, 0, 0, 0, 32'h000, 0, 0, 1, 32'h100, 0));
    tbl.push_back(row(1, 5, 0, 0, 32'h104, 0, 0, 0, 32'h100, 1));
    tbl.push_back(row(1, 6, 5, 0, 32'h108, 0, 0, 1, 32'h104, 1));
    tbl.push_back(row(0, 0, 0, 0, 32'h000, 0, 0, 0, 32'h104, 1));
    tbl.push_back(row(0, 0, 0, 0, 32'h000, 0, 0, 0, 32'h104, 1));
    if (BYP) begin
      tbl.push_back(row(0, 0, 0, 0, 32'h000, 1, 5, 1, 32'h108, 0));
      tbl.push_back(row(0, 0, 0, 0, 32'h000, 0, 0, 0, 32'h108, 0));
    end else begin
      tbl.push_back(row(0, 0, 0, 0, 32'h000, 1, 5, 0, 32'h104, 1));
      tbl.push_back(row(0, 0, 0, 0, 32'h000, 0, 0, 1, 32'h108, 0));
    end
    tbl.push_back(row(0, 0, 0, 0, 32'h000, 1, 3, 0, 32'h108, 0));
    tbl.push_back(row(0, 0, 0, 0, 32'h000, 1, 6, 0, 32'h108, 0));
    // rd=0 producer followed by an rs1=0 consumer: back-to-back issue.
    tbl.push_back(row(1, 0, 1, 2, 32'h200, 0, 0, 0, 32'h108, 1));
    tbl.push_back(row(1, 4, 0, 0, 32'h204, 0, 0, 1, 32'h200, 1));
    tbl.push_back(row(0, 0, 0, 0, 32'h000, 0, 0, 1, 32'h204, 0));
    tbl.push_back(row(0, 0, 0, 0, 32'h000, 1, 4, 0, 32'h204, 0));

    bus.i_fetch_valid = 0; bus.i_fetch_instr = '0; bus.i_fetch_pc = '0;
    bus.i_wb_valid = 0; bus.i_wb_rd = '0; bus.i_stall = 0; bus.i_invalidate = 0;
    model_reset();
    repeat (3) @(posedge i_clk);
    #1; i_rst = 1'b0;
    check_model();
    chk("reset_ready", bus.o_fetch_ready, 1);
    chk("reset_occ",   bus.o_occupancy, 0);
    chk("reset_data",  {bus.o_exec_valid, bus.o_exec_pc}, 0);

    foreach (tbl[i]) begin
      cyc(tbl[i].fv, ins(tbl[i].rd, tbl[i].rs1, tbl[i].rs2), tbl[i].pc, tbl[i].wbv, tbl[i].wbrd);
      chk($sformatf("tbl%0d_valid", i), bus.o_exec_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_occ", i), bus.o_occupancy, tbl[i].eocc);
      if (tbl[i].ev) chk($sformatf("tbl%0d_pc", i), bus.o_exec_pc, tbl[i].epc);
      if (i == 1) chk("first_rd_we", {bus.o_exec_rd, bus.o_exec_rd_we}, {5'd3, 1'b1});
      if (i == 11) chk("rd0_we", bus.o_exec_rd_we, 0);
    end

    // Stall with a held output while the FIFO fills; 5th push ignored.
    cyc(1, ins(7, 0, 0), 32'h300);
    idle();
    chk("stall_pre", {bus.o_exec_valid, bus.o_exec_pc}, {1'b1, 32'h300});
    for (int k = 0; k < 5; k++) begin
      cyc(1, ins(8 + k, 0, 0), 32'h304 + 32'(4 * k), 0, 0, 1);
      chk($sformatf("stall%0d_hold", k), {bus.o_exec_valid, bus.o_exec_pc, bus.o_exec_rd},
          {1'b1, 32'h300, 5'd7});
      ocnt = (k + 1 > DEPTH) ? DEPTH : k + 1;
      chk($sformatf("stall%0d_occ", k), bus.o_occupancy, ocnt);
      chk($sformatf("stall%0d_rdy", k), bus.o_fetch_ready, (k < 3));
    end

    // Flush: output (rd7) and FIFO dropped, r7 released.
    cyc(0, '0, '0, 0, 0, 0, 1);
    chk("inv_valid", bus.o_exec_valid, 0);
    chk("inv_occ", bus.o_occupancy, 0);
    cyc(1, ins(9, 7, 0), 32'h400);
    idle();
    chk("post_inv_issue", {bus.o_exec_valid, bus.o_exec_pc}, {1'b1, 32'h400});
    cyc(0, '0, '0, 1, 9);

    // Streaming: push every cycle, one-entry steady occupancy, in-order PCs.
    for (int i = 0; i < 2 * DEPTH + 3; i++) begin
      cyc(1, ins(0, 0, 0, 32'hABC00013 + 32'(i)), 32'h500 + 32'(4 * i));
      chk($sformatf("strm%0d_occ", i), bus.o_occupancy, 1);
      if (i > 0) chk($sformatf("strm%0d_pc", i), {bus.o_exec_valid, bus.o_exec_pc},
                     {1'b1, 32'h500 + 32'(4 * (i - 1))});
    end
    idle();
    chk("strm_last", {bus.o_exec_valid, bus.o_exec_pc}, {1'b1, 32'h528});
    idle();

    // Asynchronous reset in the middle of a cycle.
    cyc(1, ins(2, 0, 0), 32'h600);
    cyc(1, ins(3, 2, 0), 32'h604);
    #3; i_rst = 1'b1; #1;
    chk("arst_valid", bus.o_exec_valid, 0);
    chk("arst_occ", bus.o_occupancy, 0);
    chk("arst_data", {bus.o_exec_pc, bus.o_exec_instr}, 0);
    model_reset();
    @(posedge i_clk); #1; i_rst = 1'b0;
    check_model();
    cyc(1, ins(3, 2, 0), 32'h608);   // r2 no longer pending after reset
    idle();
    chk("arst_sb_clear", {bus.o_exec_valid, bus.o_exec_pc}, {1'b1, 32'h608});

    // Randomised traffic against the model.
    for (int n = 0; n < 600; n++) begin
      cyc(($urandom % 3) != 0,
          ins($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom),
          $urandom,
          ($urandom % 3) == 0, $urandom_range(0, 7),
          ($urandom % 4) == 0, ($urandom % 40) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
